// File: rtl/pipelined_addsub.sv
// Carry-segmented pipelined adder/subtractor with valid/ready handshake.
// Each stage resolves one CHUNK-bit slice; the pipeline stalls as a whole under backpressure.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits not yet consumed when this stage computes.
    localparam int unsigned Rem = WIDTH - k * CHUNK;

    logic [Rem-1:0]           a_in;
    logic [Rem-1:0]           b_in;
    logic                     c_in;
    logic                     vld_in;
    logic                     sa_in;
    logic                     sb_in;
    logic [CHUNK:0]           add;
    logic [(k+1)*CHUNK-1:0]   sum_d;

    logic                     vld_q;
    logic                     c_q;
    logic                     sa_q;
    logic                     sb_q;
    logic [(k+1)*CHUNK-1:0]   sum_q;

    assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign vld_in = in_valid;
      assign sa_in  = a[WIDTH-1];
      assign sb_in  = b_eff[WIDTH-1];
      assign sum_d  = add[CHUNK-1:0];
    end else begin : g_src
      assign a_in   = g_stg[k-1].g_dly.a_q;
      assign b_in   = g_stg[k-1].g_dly.b_q;
      assign c_in   = g_stg[k-1].c_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign sa_in  = g_stg[k-1].sa_q;
      assign sb_in  = g_stg[k-1].sb_q;
      // New chunk lands above the already-resolved low chunks.
      assign sum_d  = {add[CHUNK-1:0], g_stg[k-1].sum_q};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sa_q  <= 1'b0;
        sb_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        c_q   <= add[CHUNK];
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_dly
      logic [Rem-CHUNK-1:0] a_q;
      logic [Rem-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[Rem-1:CHUNK];
          b_q <= b_in[Rem-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign sum       = g_stg[STAGES-1].sum_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign overflow  = (g_stg[STAGES-1].sa_q == g_stg[STAGES-1].sb_q) &&
                     (sum[WIDTH-1] != g_stg[STAGES-1].sa_q);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: randomized and directed beats checked against
// an arithmetic reference model; small-width instances check STAGES=2 and STAGES=1 latency.
module tb_pipelined_addsub;

  localparam int unsigned ST = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub;
  logic        out_valid, out_ready, cout, overflow;
  logic [31:0] a, b, sum;

  logic        s_in_valid, s_cin, s_sub, s_out_ready;
  logic [7:0]  s_a, s_b;
  logic        s2_in_ready, s2_out_valid, s2_cout, s2_ovf;
  logic        s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
  logic [7:0]  s2_sum, s1_sum;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   bp_en = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  pipelined_addsub #(.WIDTH(32), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .overflow(overflow)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s2_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(s2_out_valid), .out_ready(s_out_ready),
    .sum(s2_sum), .cout(s2_cout), .overflow(s2_ovf)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s1_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(s1_out_valid), .out_ready(s_out_ready),
    .sum(s1_sum), .cout(s1_cout), .overflow(s1_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input logic sv);
    exp_t        m;
    longint      sa, sbv, r;
    logic [32:0] u;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    if (sv) begin
      r      = sa - sbv;
      m.sum  = av - bv;
      m.cout = (av >= bv);
    end else begin
      r      = sa + sbv + longint'(cv);
      u      = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
      m.sum  = u[31:0];
      m.cout = u[32];
    end
    m.ovf = (r > SMAX) || (r < SMIN);
    return m;
  endfunction

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                      input logic sv, output int acc);
    logic rdy;
    bit   done;
    done = 0;
    acc = -1;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      acc = cyc;
      @(posedge clk);
      if (rdy) begin
        sb.push_back(model(av, bv, cv, sv));
        done = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles want 1");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic sv, input logic [31:0] es,
                          input logic ec, input logic eo);
    int acc;
    out_ready = 1'b1;
    send(av, bv, cv, sv, acc);
    repeat (ST - 2) @(posedge clk);
    @(negedge clk);
    chk({nm, "_early_valid"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_latency"}, cyc - acc, ST);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, overflow, eo);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [6];
    corner = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'h0000_FFFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Monitor: pops the scoreboard on every output transfer, checks stall stability.
  initial begin
    exp_t e, h;
    bit   held_v;
    held_v = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 0;
      end else begin
        if (held_v) begin
          chk("hold_sum", sum, h.sum);
          chk("hold_cout", cout, h.cout);
          chk("hold_ovf", overflow, h.ovf);
        end
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", in_ready, 0);
          h = '{sum, cout, overflow};
          held_v = 1;
        end else begin
          held_v = 0;
          if (out_valid) begin
            if (sb.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_out: got sum %0h want no beat", sum);
            end else begin
              e = sb.pop_front();
              chk("sb_sum", sum, e.sum);
              chk("sb_cout", cout, e.cout);
              chk("sb_ovf", overflow, e.ovf);
              pop_cyc.push_back(cyc);
            end
          end
        end
      end
    end
  end

  // Random backpressure, only while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc0;
    rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
    s_in_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0; s_out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    directed("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("neg_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("borrow", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Back-to-back stream, no stall.
    pop_cyc.delete();
    out_ready = 1'b1;
    acc0 = 0;
    for (int i = 0; i < 8; i++) begin
      send(i, i * 3, i[0], 1'b0, acc);
      if (i == 0) acc0 = acc;
    end
    drain();
    chk("stream_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      chk("stream_first_latency", pop_cyc[0] - acc0, ST);
      chk("stream_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
    end

    // Stream with a 3-cycle output stall in the middle.
    fork
      for (int i = 0; i < 8; i++) send(i + 100, (i + 100) * 3, i[0], 1'b0, acc);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight.
    for (int i = 0; i < 3; i++) send(32'h1000 + i, 32'h22, 1'b1, 1'b0, acc);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    // Narrow instances: STAGES=2 latency 2, STAGES=1 latency 1.
    s_a = 8'hF8; s_b = 8'h08; s_cin = 1'b1; s_sub = 1'b0; s_in_valid = 1'b1;
    @(negedge clk);
    chk("s2_in_ready", s2_in_ready, 1);
    chk("s1_in_ready", s1_in_ready, 1);
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("s1_valid_c%0d", k), s1_out_valid, (k == 1));
      chk($sformatf("s2_valid_c%0d", k), s2_out_valid, (k == 2));
      if (k == 1) begin
        chk("s1_sum", s1_sum, 8'h01);
        chk("s1_cout", s1_cout, 1);
        chk("s1_ovf", s1_ovf, 0);
      end
      if (k == 2) begin
        chk("s2_sum", s2_sum, 8'h01);
        chk("s2_cout", s2_cout, 1);
        chk("s2_ovf", s2_ovf, 0);
      end
    end
    @(posedge clk);
    #1;

    // Randomized traffic with idle gaps and random backpressure.
    bp_en = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    end
    bp_en = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, carry-segmented pipelined adder/subtractor; next generation of the team's 8-bit 2-step adder.
- Splits a WIDTH-bit operation into STAGES equal chunks. Each pipeline stage resolves one chunk and passes its carry forward.
- Adds a valid/ready handshake with backpressure, a subtract mode, signed-overflow reporting and synchronous reset.
- Sits in the datapath as a high-frequency replacement for a flat adder.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry segments; 1..WIDTH.
- CHUNK, WIDTH/STAGES, derived (localparam); bits resolved per stage.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B, i.e. A+~B+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (sub: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all stage valid bits=0 and all data/carry registers=0. Outputs during and after reset: out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded; nothing emerges after rst deasserts.
- Pipeline advance: adv = !out_valid | out_ready. in_ready = adv (combinational). All stages shift together when adv=1 and hold when adv=0 (global stall). Bubbles are not squeezed.
- Accept: a beat is taken when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Operand preparation at entry:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
  - Also capture sign bits a[WIDTH-1] and b_eff[WIDTH-1] for overflow.
- Stage k (0..STAGES-1):
  - Computes {c_k+1, s_k} = a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + c_k, in CHUNK+1 bits. c_k is the carry registered by stage k-1, or c0 for k=0.
  - Completed low chunks travel forward in skew registers.
  - Unconsumed high operand chunks travel forward in delay registers.
  - Only chunk-wide adders are allowed; no WIDTH-wide carry chain.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready is held 1. Throughput: 1 beat/cycle.
- Outputs are registered from the last stage:
  - sum = concatenation of all chunks.
  - cout = c_STAGES.
  - overflow = (sa == sb_eff) & (sum[WIDTH-1] != sa).
- Output hold: while out_valid=1 and out_ready=0, sum, cout and overflow hold stable, and in_ready=0.
- Simultaneous events:
  - out_ready=1 with in_valid=1 on a full pipe: accept and drain occur in the same cycle, with no bubble inserted.
  - rst=1 overrides all handshakes.
- STAGES=1: degenerates to a single registered adder with latency 1.
- Wrap-around: the result is modulo 2^WIDTH; carry and borrow are visible only through cout.
- Ordering: beats emerge in acceptance order; no reordering.

Test Plan:
- Default params, sub=0, a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles out_valid=1, sum=0x00000000, cout=1, overflow=0 (carry ripples through all stages).
- sub=0, a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1. Then sub=1, a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0.
- Back-to-back stream of 8 beats (a=i, b=i*3, cin=i&1) with out_ready=1 -> results 4i+(i&1) on consecutive cycles starting at cycle 4, in order. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs stable, no beat lost or duplicated.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0 and all outputs 0 next cycle, in_ready=1, no stale beat appears afterward.
- WIDTH=8, STAGES=2: a=0xF8, b=0x08, cin=1 -> sum=0x01, cout=1, latency 2. STAGES=1: the same operands -> latency 1.
